stream_demux_1_4: RTL and testbench

Registered 1-to-4 stream demultiplexer. It routes each 4-bit word from a single valid/ready input stream to one of four valid/ready output streams, chosen by a 2-bit select sampled with the word. It is the distribution-side counterpart of the 4:1 selector tree: one producer feeds four consumers. Each output has its own one-entry holding slot, so a stalled consumer blocks only traffic addressed to it.

---
 rtl/stream_demux_pkg.sv | 29 ++
 rtl/stream_slot.sv | 81 ++++++++
 rtl/stream_demux_1_4.sv | 55 +++++
 tb/tb_stream_demux_1_4.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared parameters, types and helpers for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // A slot is either empty or holding exactly one word.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // One-hot decode of a destination index; an unknown index selects nothing.
  function automatic logic [N_OUT-1:0] sel_onehot(input sel_t sel);
    logic [N_OUT-1:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready holding register with a count of completed drains.
// A load and a drain in the same cycle keep the slot full with the new word.
module stream_slot
  import stream_demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt
);

  slot_state_t      state_r;
  slot_state_t      state_nx;
  logic             drain_s;
  logic [W-1:0]     data_r;
  logic [CNT_W-1:0] cnt_r;

  assign drain_s = (state_r == SLOT_FULL) & out_ready;

  // Next-state: fill on load, empty only on a drain that is not refilled.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (load) begin
          state_nx = SLOT_FULL;
        end else begin
          state_nx = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          state_nx = SLOT_FULL;
        end else if (out_ready) begin
          state_nx = SLOT_EMPTY;
        end else begin
          state_nx = SLOT_FULL;
        end
      end
      default: state_nx = SLOT_EMPTY;
    endcase
  end

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_nx;
    end
  end

  // Word storage; only an accepted load changes it, so stale data lingers while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {W{1'b0}};
    end else if (load) begin
      data_r <= load_data;
    end
  end

  // Completed-handshake counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (drain_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign out_valid = (state_r == SLOT_FULL);
  assign out_data  = data_r;
  assign cnt       = cnt_r;

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer: each input word is steered by
// in_sel into one of four independent one-entry output slots.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*W-1:0]     out_data,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*CNT_W-1:0] xfer_cnt
);

  logic [N_OUT-1:0] slot_valid_s;
  logic [N_OUT-1:0] load_s;
  logic             accept_s;

  // The addressed slot can take a word if it is empty or is being drained now.
  assign in_ready = ~slot_valid_s[in_sel] | out_ready[in_sel];
  assign accept_s = in_valid & in_ready;

  // Steer an accepted word to exactly one slot.
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      load_s = sel_onehot(sel_t'(in_sel));
    end else begin
      load_s = 4'b0000;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    stream_slot #(
      .W(W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s[i]),
      .load_data(in_data),
      .out_valid(slot_valid_s[i]),
      .out_data (out_data[i*W +: W]),
      .out_ready(out_ready[i]),
      .cnt      (xfer_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign out_valid = slot_valid_s;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed and random self-checking bench for stream_demux_1_4.
module tb_stream_demux_1_4;
  import stream_demux_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ready;
  logic [31:0] xfer_cnt;

  int n_checks;
  int n_pass;

  stream_demux_1_4 #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sbq [4][$];
  logic [3:0] mvalid;
  logic [7:0] mcnt [4];
  logic [31:0] exp_cnt;
  logic [3:0] exp4;
  logic       exp_rdy;
  logic       pending;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'h0;
    out_ready = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_xfer_cnt", xfer_cnt, 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // Routing to each output on consecutive cycles
    tick();
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 4'ha + 4'(i);
      #1;
      check("route_in_ready", 32'(in_ready), 32'h1);
      tick();
      exp4 = 4'ha + 4'(i);
      check("route_valid", 32'(out_valid[i]), 32'h1);
      check("route_data", 32'(out_data[i*4 +: 4]), 32'(exp4));
    end
    in_valid = 1'b0;
    tick();
    check("route_idle_valid", 32'(out_valid), 32'h0);
    check("route_cnt", xfer_cnt, 32'h01010101);

    // Backpressure on output 1
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 4'h7;
    #1;
    check("bp_first_ready", 32'(in_ready), 32'h1);
    tick();
    in_data = 4'h3;
    #1;
    check("bp_stall_ready", 32'(in_ready), 32'h0);
    check("bp_stall_valid", 32'(out_valid), 32'h2);
    check("bp_stall_data", 32'(out_data[7:4]), 32'h7);
    tick();
    check("bp_hold_data", 32'(out_data[7:4]), 32'h7);
    check("bp_hold_valid", 32'(out_valid), 32'h2);
    in_sel  = 2'd2;
    in_data = 4'h5;
    #1;
    check("bp_other_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_other_valid", 32'(out_valid), 32'h6);
    check("bp_other_data", 32'(out_data[11:8]), 32'h5);
    in_sel  = 2'd1;
    in_data = 4'h3;
    #1;
    check("bp_stall2_ready", 32'(in_ready), 32'h0);
    tick();
    check("bp_after_drain2", 32'(out_valid), 32'h2);
    out_ready = 4'b1111;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("bp_new_data", 32'(out_data[7:4]), 32'h3);
    check("bp_new_valid", 32'(out_valid), 32'h2);
    tick();
    check("bp_end_valid", 32'(out_valid), 32'h0);
    check("bp_cnt", xfer_cnt, 32'h01020301);

    // Back-to-back stream into output 3 (drain and load together)
    for (int j = 1; j <= 8; j++) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 4'(j);
      #1;
      check("stream_ready", 32'(in_ready), 32'h1);
      tick();
      check("stream_valid", 32'(out_valid[3]), 32'h1);
      check("stream_data", 32'(out_data[15:12]), 32'(j));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 32'h0);
    check("stream_cnt", xfer_cnt, 32'h09020301);

    // Asynchronous reset with slot 2 full
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 4'h9;
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_full", 32'(out_valid), 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    check("mid_rst_cnt", xfer_cnt, 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;

    // Counter wrap on output 0
    out_ready = 4'b1111;
    for (int j = 0; j < 256; j++) begin
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 4'(j);
      tick();
    end
    check("wrap_255", xfer_cnt, 32'h000000ff);
    in_valid = 1'b0;
    tick();
    check("wrap_zero", xfer_cnt, 32'h0);
    check("wrap_valid", 32'(out_valid), 32'h0);

    // Random regression against a per-output scoreboard
    mvalid  = 4'b0000;
    pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 8'd0;
    end
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 4'($urandom_range(0, 15));
      end
      out_ready = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = ~mvalid[in_sel] | out_ready[in_sel];
      check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("rnd_valid", 32'(out_valid), 32'(mvalid));
      for (int i = 0; i < 4; i++) begin
        if (mvalid[i] && out_ready[i]) begin
          if (sbq[i].size() == 0) begin
            check("rnd_sb_empty", 32'(sbq[i].size()), 32'h1);
          end else begin
            check("rnd_data", 32'(out_data[i*4 +: 4]), 32'(sbq[i][0]));
            void'(sbq[i].pop_front());
          end
          mcnt[i] = mcnt[i] + 8'd1;
          mvalid[i] = 1'b0;
        end
      end
      if (in_valid && exp_rdy) begin
        sbq[in_sel].push_back(in_data);
        mvalid[in_sel] = 1'b1;
        pending = 1'b0;
      end else begin
        pending = in_valid;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    exp_cnt = {mcnt[3], mcnt[2], mcnt[1], mcnt[0]};
    check("rnd_cnt", xfer_cnt, exp_cnt);
    check("rnd_end_valid", 32'(out_valid), 32'(mvalid));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
